// File: rtl/key_pkg.sv
// Shared key-gesture definitions: FSM state encoding and default gesture timings.
// Reused by the classifier and any future multi-key scanner.
package key_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } key_state_t;

    localparam int DEF_LONG_MS   = 1000;
    localparam int DEF_DOUBLE_MS = 300;
    localparam int DEF_REPEAT_MS = 200;

    // ms_cnt value at which the next tick completes an N ms interval
    function automatic logic [15:0] ms_last(input int ms);
        return 16'(ms - 1);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Restartable 1 ms tick: tick is high on the (CLK_FREQ_MHZ*1000)-th cycle after clr or the previous tick.
// clr restarts the count on the next edge; no backpressure.
module ms_tick_gen #(
    parameter int CLK_FREQ_MHZ = 100
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int              PERIOD = CLK_FREQ_MHZ * 1000;
    localparam int              W      = $clog2(PERIOD);
    localparam logic [W-1:0]    LAST   = W'(PERIOD - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/key_press_classifier.sv
// Turns debounced press/release pulses of one key into click, double click, long press, repeat and release gestures.
// Every output is a registered 1-cycle pulse, 1 clk after its cause; no backpressure.
module key_press_classifier
    import key_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int LONG_MS      = DEF_LONG_MS,
    parameter int DOUBLE_MS    = DEF_DOUBLE_MS,
    parameter int REPEAT_MS    = DEF_REPEAT_MS
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic key_down_one_time,
    input  logic key_up_one_time,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic long_repeat,
    output logic long_release,
    output logic busy
);

    localparam logic [15:0] LONG_LAST   = ms_last(LONG_MS);
    localparam logic [15:0] DOUBLE_LAST = ms_last(DOUBLE_MS);
    localparam logic [15:0] REPEAT_LAST = ms_last(REPEAT_MS);

    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    key_state_t  r_state;
    key_state_t  w_nxt;
    logic [15:0] r_ms_cnt;
    logic        w_tick;
    logic        w_dn;
    logic        w_up;
    logic        w_clr;
    logic        w_ms_clr;
    logic        w_fire_click;
    logic        w_fire_dbl;
    logic        w_fire_lp;
    logic        w_fire_rep;
    logic        w_fire_lr;
    logic        r_click;
    logic        r_dbl;
    logic        r_lp;
    logic        r_rep;
    logic        r_lr;

    // Assert asynchronously, release two clocks after rstn rises
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    // Simultaneous press and release cannot come from the debouncer; drop both
    assign w_dn = key_down_one_time & ~key_up_one_time;
    assign w_up = key_up_one_time & ~key_down_one_time;

    always_comb begin
        w_nxt        = r_state;
        w_fire_click = 1'b0;
        w_fire_dbl   = 1'b0;
        w_fire_lp    = 1'b0;
        w_fire_rep   = 1'b0;
        w_fire_lr    = 1'b0;
        if (!en) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dn) w_nxt = S_PRESS1;
                end
                S_PRESS1: begin
                    if (w_up) begin
                        w_nxt = S_WAIT2;
                    end else if (w_tick && r_ms_cnt == LONG_LAST) begin
                        w_fire_lp = 1'b1;
                        w_nxt     = S_LONG;
                    end
                end
                S_WAIT2: begin
                    if (w_dn) begin
                        w_nxt = S_PRESS2;
                    end else if (w_tick && r_ms_cnt == DOUBLE_LAST) begin
                        w_fire_click = 1'b1;
                        w_nxt        = S_IDLE;
                    end
                end
                S_PRESS2: begin
                    if (w_up) begin
                        w_fire_dbl = 1'b1;
                        w_nxt      = S_IDLE;
                    end else if (w_tick && r_ms_cnt == LONG_LAST) begin
                        w_fire_click = 1'b1;
                        w_fire_lp    = 1'b1;
                        w_nxt        = S_LONG;
                    end
                end
                S_LONG: begin
                    if (w_up) begin
                        w_fire_lr = 1'b1;
                        w_nxt     = S_IDLE;
                    end else if (w_tick && r_ms_cnt == REPEAT_LAST) begin
                        w_fire_rep = 1'b1;
                    end
                end
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    // Repeat restarts only ms_cnt; the prescaler has just wrapped, so periods do not drift
    assign w_clr    = !en || (w_nxt != r_state);
    assign w_ms_clr = w_clr || w_fire_rep;

    ms_tick_gen #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
    ) u_ms_tick (
        .clk  (clk),
        .rstn (w_rst_n),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ms_cnt <= 16'd0;
        end else if (w_ms_clr) begin
            r_ms_cnt <= 16'd0;
        end else if (w_tick) begin
            r_ms_cnt <= r_ms_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_click <= 1'b0;
            r_dbl   <= 1'b0;
            r_lp    <= 1'b0;
            r_rep   <= 1'b0;
            r_lr    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_click <= w_fire_click;
            r_dbl   <= w_fire_dbl;
            r_lp    <= w_fire_lp;
            r_rep   <= w_fire_rep;
            r_lr    <= w_fire_lr;
        end
    end

    assign click        = r_click;
    assign double_click = r_dbl;
    assign long_press   = r_lp;
    assign long_repeat  = r_rep;
    assign long_release = r_lr;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier at 1 MHz with LONG=10, DOUBLE=5, REPEAT=3 ms.
// Gesture table plus hand-written reset and enable disturbance sequences.
module tb_key_press_classifier;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic en = 1'b1;
    logic dn = 1'b0;
    logic up = 1'b0;
    logic click, dbl, lp, rep, lr, busy;

    key_press_classifier #(
        .CLK_FREQ_MHZ(1),
        .LONG_MS     (10),
        .DOUBLE_MS   (5),
        .REPEAT_MS   (3)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .en               (en),
        .key_down_one_time(dn),
        .key_up_one_time  (up),
        .click            (click),
        .double_click     (dbl),
        .long_press       (lp),
        .long_repeat      (rep),
        .long_release     (lr),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // index 0 click, 1 double_click, 2 long_press, 3 long_repeat, 4 long_release
    wire [4:0] w_out = {lr, rep, lp, dbl, click};
    int ev_cyc[$];
    int ev_id[$];
    always @(negedge clk) begin
        for (int j = 0; j < 5; j++) begin
            if (w_out[j]) begin
                ev_cyc.push_back(cyc);
                ev_id.push_back(j);
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    int cnt[5];
    int tfirst[5];
    int tlast[5];

    task automatic tally(input int qs, input int t0);
        for (int j = 0; j < 5; j++) begin
            cnt[j] = 0; tfirst[j] = -1; tlast[j] = -1;
        end
        for (int i = qs; i < ev_id.size(); i++) begin
            cnt[ev_id[i]]++;
            if (tfirst[ev_id[i]] < 0) tfirst[ev_id[i]] = ev_cyc[i] - t0;
            tlast[ev_id[i]] = ev_cyc[i] - t0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        string name;
        int dn0, up0, dn1, up1, run;
        int cc, cd, cl, cr, cx;
        int tc, td, tl, tr, trl, tx;
    } vec_t;

    vec_t tv[7];
    string nm_ev[5] = '{"click", "dbl", "lp", "rep", "lr"};

    initial begin
        int ec[5];
        int et[5];
        int qs, t0;

        tv[0] = '{"single",    0, 2000,   -1,    -1,  7500, 1,0,0,0,0, 7001,0,0,0,0,0};
        tv[1] = '{"double",    0, 2000, 3000,  5000,  7000, 0,1,0,0,0, 0,5001,0,0,0,0};
        tv[2] = '{"long",      0, 20000,  -1,    -1, 20100, 0,0,1,3,1, 0,0,10001,13001,19001,20001};
        tv[3] = '{"taphold",   0, 2000, 3000, 15000, 15100, 1,0,1,0,1, 13001,0,13001,0,0,15001};
        tv[4] = '{"dn_on_exp", 0, 2000, 7000,  8000,  8200, 0,1,0,0,0, 0,8001,0,0,0,0};
        tv[5] = '{"up_idle",  -1,    0,   -1,    -1,  1500, 0,0,0,0,0, 0,0,0,0,0,0};
        tv[6] = '{"dn_up_same",0, 2000, 3000,  3000,  7200, 1,0,0,0,0, 7001,0,0,0,0,0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", int'(w_out), 0);
        chk("reset_busy", int'(busy), 0);
        rstn = 1'b1;
        wait_cyc(5);
        chk("post_reset_busy", int'(busy), 0);

        for (int v = 0; v < 7; v++) begin
            qs = ev_id.size();
            t0 = cyc;
            for (int k = 0; k < tv[v].run; k++) begin
                dn = (k == tv[v].dn0) || (k == tv[v].dn1);
                up = (k == tv[v].up0) || (k == tv[v].up1);
                @(posedge clk);
                #1;
            end
            dn = 1'b0;
            up = 1'b0;
            tally(qs, t0);
            ec = '{tv[v].cc, tv[v].cd, tv[v].cl, tv[v].cr, tv[v].cx};
            et = '{tv[v].tc, tv[v].td, tv[v].tl, tv[v].tr, tv[v].tx};
            for (int j = 0; j < 5; j++) begin
                chk({tv[v].name, "_cnt_", nm_ev[j]}, cnt[j], ec[j]);
                if (ec[j] > 0) chk({tv[v].name, "_t_", nm_ev[j]}, tfirst[j], et[j]);
            end
            if (tv[v].cr > 1) chk({tv[v].name, "_t_rep_last"}, tlast[3], tv[v].trl);
            chk({tv[v].name, "_busy_end"}, int'(busy), 0);
        end

        // Reset in the middle of a press abandons the gesture
        qs = ev_id.size();
        dn = 1'b1;
        wait_cyc(1);
        dn = 1'b0;
        wait_cyc(500);
        chk("rst_busy_before", int'(busy), 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_busy_async", int'(busy), 0);
        chk("rst_outs_async", int'(w_out), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        wait_cyc(5);
        up = 1'b1;
        wait_cyc(1);
        up = 1'b0;
        wait_cyc(6500);
        tally(qs, 0);
        chk("rst_no_pulses", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4], 0);
        chk("rst_busy_end", int'(busy), 0);

        // Dropping enable for one cycle while long-held cancels the gesture
        qs = ev_id.size();
        t0 = cyc;
        dn = 1'b1;
        wait_cyc(1);
        dn = 1'b0;
        wait_cyc(10500);
        tally(qs, t0);
        chk("en_lp_cnt", cnt[2], 1);
        chk("en_lp_t", tfirst[2], 10001);
        chk("en_busy_long", int'(busy), 1);
        en = 1'b0;
        wait_cyc(1);
        chk("en_busy_low", int'(busy), 0);
        chk("en_outs_low", int'(w_out), 0);
        en = 1'b1;
        qs = ev_id.size();
        wait_cyc(100);
        up = 1'b1;
        wait_cyc(1);
        up = 1'b0;
        wait_cyc(3000);
        tally(qs, 0);
        chk("en_no_release", cnt[4], 0);
        chk("en_no_repeat", cnt[3], 0);
        chk("en_busy_end", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_press_classifier.md
Name: key_press_classifier

Overview:
- Sequences the debounced event pulses of one key (key_down_one_time / key_up_one_time from keyEliminateJitter) into user-level gestures: single click, double click, long press, auto-repeat while held, and long-press release.
- Sits between each keyEliminateJitter instance and the application logic (LED/menu control), one instance per key, in the same clk domain.

Parameters:
- CLK_FREQ_MHZ, 100, clk frequency in MHz; sets the 1 ms tick period of CLK_FREQ_MHZ*1000 clk cycles.
- LONG_MS, 1000, hold time in ms before long_press fires; legal range 2..65535.
- DOUBLE_MS, 300, maximum release-to-second-press gap in ms for double_click; legal range 2..65535.
- REPEAT_MS, 200, long_repeat period in ms while held after long_press; legal range 2..65535.

Ports:
- clk  input  1  system clock, same clk as keyEliminateJitter.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  classifier enable; low forces IDLE and suppresses all outputs.
- key_down_one_time  input  1  1-cycle pulse on debounced press.
- key_up_one_time  input  1  1-cycle pulse on debounced release.
- click  output  1  1-cycle pulse: single click recognised.
- double_click  output  1  1-cycle pulse: double click recognised.
- long_press  output  1  1-cycle pulse: hold reached LONG_MS.
- long_repeat  output  1  1-cycle pulse every REPEAT_MS after long_press while held.
- long_release  output  1  1-cycle pulse: key released after long_press.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: rstn low asynchronously sets FSM=IDLE, ms_cnt=0, prescaler=0, and all outputs 0. Reset deassertion is synchronised to clk (2-flop), per the team reset policy.
- All outputs are registered. A pulse appears exactly 1 clk after the input pulse or ms tick that causes it.
- ms timing:
  - The prescaler and ms_cnt (16 bit) clear on every state change, so each measured interval is exact.
  - The prescaler emits a tick on its (CLK_FREQ_MHZ*1000)-th cycle.
  - An interval of N ms expires on the tick that brings ms_cnt to N.
- States and transitions:
  - IDLE: down pulse -> PRESS1. Up pulse -> ignored.
  - PRESS1:
    - Up pulse before expiry -> WAIT2.
    - ms_cnt reaches LONG_MS -> fire long_press, go to LONG.
  - WAIT2:
    - Down pulse before DOUBLE_MS expires -> PRESS2.
    - Expiry -> fire click, go to IDLE.
  - PRESS2:
    - Up pulse -> fire double_click, go to IDLE.
    - ms_cnt reaches LONG_MS -> fire click and long_press in the same cycle, go to LONG (first tap = click, second = long hold).
  - LONG:
    - Each REPEAT_MS expiry -> fire long_repeat. The counter restarts, with no drift.
    - Up pulse -> fire long_release, go to IDLE. No further repeats.
- Boundary conditions:
  - Up pulse and expiry tick in the same cycle: the up pulse wins (press is short; the release is honoured).
  - Down pulse and WAIT2 expiry in the same cycle: the down pulse wins -> PRESS2.
  - Down and up pulses in the same cycle: both are ignored and the state is held (the debouncer cannot produce this).
  - Redundant pulses (down while pressed, up while released) are ignored.
  - en low: the next edge forces IDLE and clears the counters. Outputs are 0 while en is low. No gesture completes across an en low period.
  - Reset mid-gesture: the gesture is abandoned and nothing fires.
  - The ms_cnt compare uses parameter values sized to 16 bit, with no wrap possible inside legal ranges.

Decomposition:
- Shared package/header key_pkg:
  - FSM state encoding localparams: IDLE, PRESS1, WAIT2, PRESS2, LONG (3-bit).
  - Default LONG_MS / DOUBLE_MS / REPEAT_MS constants, shared with any future multi-key scanner.
- One sub-module: ms_tick_gen.
  - Parameter: CLK_FREQ_MHZ.
  - Ports: clk, rstn, clr, tick.
  - Function: restartable 1 ms tick.
- All of the above is reusable by other key/timer blocks.

Test Plan (CLK_FREQ_MHZ=1, LONG_MS=10, DOUBLE_MS=5, REPEAT_MS=3; 1 ms = 1000 cycles):
- Single click: down pulse, up pulse after 2000 cycles -> exactly one click, 5001 cycles after the up pulse. No other outputs fire.
- Double click: down, up at +2000, down at +3000, up at +5000 -> one double_click, 1 cycle after the second up pulse. No click.
- Long press with repeat: down, hold 20 ms, up -> long_press at +10001 cycles; long_repeat at +13001, +16001, +19001; long_release 1 cycle after the up pulse.
- Tap then hold: down, up at +2000, down at +3000, hold 12 ms -> click and long_press in the same cycle at 10001 cycles after the second down pulse.
- Boundary: in WAIT2, drive the down pulse on the exact cycle of the DOUBLE_MS expiry tick -> no click; release then yields double_click.
- Disturbance:
  - rstn asserted mid-PRESS1 -> all outputs 0 immediately (asynchronous); no pulses after release.
  - en low for 1 cycle mid-LONG -> no long_release, and busy=0.
